// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan receiver: glyph codes,
// digit count, FSM state encoding and the digit-select decoder.
package seg_pkg;

  localparam int DIGITS = 4;

  // Active-low gfedcba patterns of the sixteen hex glyphs.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCEPT,
    HOLD
  } scan_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } sel_dec_t;

  // Active-low one-hot select to digit index; blank or multi-low is "no digit".
  function automatic sel_dec_t decode_sel(input logic [DIGITS-1:0] sel);
    sel_dec_t r;
    r = '{valid: 1'b0, idx: 2'd0};
    case (sel)
      4'b1110: r = '{valid: 1'b1, idx: 2'd0};
      4'b1101: r = '{valid: 1'b1, idx: 2'd1};
      4'b1011: r = '{valid: 1'b1, idx: 2'd2};
      4'b0111: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '{valid: 1'b0, idx: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational seven-segment glyph decoder: active-low gfedcba pattern to
// hex value, with a flag for patterns that are not one of the sixteen glyphs.
module seg7_glyph_dec
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    val   = 4'h0;
    valid = 1'b1;
    case (seg)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_F:   val = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Receiver for a multiplexed seven-segment scan: synchronises seg/sel,
// debounces each digit visit, and commits a full four-digit frame.
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  sel_in,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        stall
);

  localparam int                 STALL_W    = $clog2(STALL_CYCLES + 1);
  localparam logic [7:0]         STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);

  logic [7:0]        seg_s1, seg_s2, prev_seg;
  logic [DIGITS-1:0] sel_s1, sel_s2, prev_sel;

  scan_state_e state;
  logic [7:0]  stab_cnt;
  logic [1:0]  idx;
  logic [7:0]  cap_seg;
  logic [DIGITS-1:0] acc_sel;
  logic [DIGITS-1:0][3:0] shadow_val;
  logic [DIGITS-1:0] shadow_dp;
  logic [DIGITS-1:0] mask;
  logic [STALL_W-1:0] stall_cnt;

  sel_dec_t   cur;
  logic       same;
  logic       sel_changed;
  logic       enter;
  logic [7:0] stab_next;
  logic [3:0] glyph_val;
  logic       glyph_ok;

  // Two-flop synchroniser plus a one-cycle history for change detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      sel_s1   <= '0;
      sel_s2   <= '0;
      prev_seg <= '0;
      prev_sel <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value
      // of its predecessor, which is what makes this a real shift chain.
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      sel_s1   <= sel_in;
      sel_s2   <= sel_s1;
      prev_seg <= seg_s2;
      prev_sel <= sel_s2;
    end
  end

  seg7_glyph_dec u_glyph (
    .seg   (cap_seg[6:0]),
    .val   (glyph_val),
    .valid (glyph_ok)
  );

  always_comb begin
    cur         = decode_sel(sel_s2);
    same        = ({seg_s2, sel_s2} == {prev_seg, prev_sel});
    sel_changed = (sel_s2 != prev_sel);
    stab_next   = stab_cnt + 8'd1;
    enter       = 1'b0;
    // A new visit starts on a valid select seen from IDLE, from a disturbed
    // SETTLE, or once HOLD sees the select move away from the accepted one.
    case (state)
      IDLE:    enter = cur.valid;
      SETTLE:  enter = cur.valid && !same;
      HOLD:    enter = cur.valid && (sel_s2 != acc_sel);
      default: enter = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      stab_cnt    <= '0;
      idx         <= '0;
      cap_seg     <= {1'b1, SEG_BLANK};
      acc_sel     <= '1;
      // NOTE: the shadow registers are reset on purpose so a partial frame
      // cannot leak into the first commit after reset.
      shadow_val  <= '0;
      shadow_dp   <= '0;
      mask        <= '0;
      digits      <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      // Commit runs in the HOLD cycle after the last ACCEPT, so it never
      // competes with a mask update from ACCEPT.
      if (mask == '1) begin
        digits      <= shadow_val;
        dp          <= shadow_dp;
        frame_valid <= 1'b1;
        mask        <= '0;
      end

      if (enter) begin
        idx      <= cur.idx;
        acc_sel  <= sel_s2;
        cap_seg  <= seg_s2;
        stab_cnt <= 8'd1;
        state    <= (STABLE_MAX == 8'd1) ? ACCEPT : SETTLE;
      end else begin
        case (state)
          IDLE: ;
          SETTLE: begin
            if (same) begin
              stab_cnt <= stab_next;
              cap_seg  <= seg_s2;
              if (stab_next == STABLE_MAX) state <= ACCEPT;
            end else begin
              state <= IDLE;
            end
          end
          ACCEPT: begin
            shadow_val[idx] <= glyph_val;
            shadow_dp[idx]  <= ~cap_seg[7];
            mask[idx]       <= 1'b1;
            if (!glyph_ok) bad_pattern <= 1'b1;
            state <= HOLD;
          end
          HOLD: begin
            if (sel_s2 != acc_sel) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Idle-scan watchdog, saturating so stall stays up until sel moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (sel_changed) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall = (stall_cnt == STALL_MAX);

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx: directed scans, a vector table,
// stall/reset corner cases and randomized scans against a frame model.
module tb_seg_scan_rx;

  localparam int STABLE = 4;
  localparam int STALL  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  sel_in = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        bad_pattern;
  logic        stall;

  seg_scan_rx #(
    .STABLE_CYCLES (STABLE),
    .STALL_CYCLES  (STALL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] segs;
    logic [3:0]      gap;
    logic [15:0]     exp_d;
    logic [3:0]      exp_p;
    logic            exp_bad;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
  } frame_t;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int     n_total = 0;
  int     n_bad   = 0;
  int     cyc     = 0;
  int     fv_count = 0;
  int     fv_cyc   = 0;
  bit     mon_en   = 1'b0;
  frame_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor: counts pulses and, in the random phase, scores them.
  initial forever begin
    frame_t f;
    @(negedge clk);
    if (frame_valid === 1'b1) begin
      fv_count++;
      fv_cyc = cyc;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL rand_extra_frame: got frame %h with none expected", digits);
        end else begin
          f = exp_q.pop_front();
          check("rand_digits", 32'(digits), 32'(f.d));
          check("rand_dp", 32'(dp), 32'(f.p));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic [3:0] s, input logic [7:0] g, input int n);
    sel_in = s;
    seg_in = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic visit(input int idx, input logic [7:0] g, input int n);
    logic [3:0] s;
    s      = 4'hF;
    s[idx] = 1'b0;
    hold(s, g, n);
  endtask

  function automatic logic [4:0] model_glyph(input logic [6:0] g);
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == g) return {1'b1, 4'(i)};
    return 5'b0_0000;
  endfunction

  logic [3:0] m_val [4];
  logic       m_dp  [4];
  logic       model_bad;
  int         last_idx;

  task automatic rand_frame();
    int order [4];
    int tmp, j, idx, gap;
    logic [6:0] g;
    logic       dpb;
    logic [4:0] dec;
    frame_t     f;
    order = '{0, 1, 2, 3};
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int k = 0; k < 4; k++) begin
      idx = order[k];
      gap = int'($urandom_range(2, 0));
      if (idx == last_idx && gap == 0) gap = 1;
      if (gap != 0) hold(4'hF, 8'hFF, gap);
      if ($urandom_range(7, 0) == 0) g = 7'($urandom);
      else g = glyph_tab[$urandom_range(15, 0)];
      dpb = 1'($urandom);
      dec = model_glyph(g);
      m_val[idx] = dec[3:0];
      m_dp[idx]  = dpb;
      if (!dec[4]) model_bad = 1'b1;
      if (k == 3) begin
        f.d = {m_val[3], m_val[2], m_val[1], m_val[0]};
        f.p = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
        exp_q.push_back(f);
      end
      if ($urandom_range(2, 0) == 0) visit(idx, 8'($urandom), int'($urandom_range(2, 1)));
      visit(idx, {~dpb, g}, int'($urandom_range(10, 6)));
      last_idx = idx;
    end
  endtask

  initial begin
    vec_t vecs [6];
    int   fvb, c0;

    vecs[0] = '{segs: 32'h9288B0C6, gap: 4'd0, exp_d: 16'h5A3C, exp_p: 4'h0, exp_bad: 1'b0};
    vecs[1] = '{segs: 32'h8883C6A1, gap: 4'd1, exp_d: 16'hABCD, exp_p: 4'h0, exp_bad: 1'b0};
    vecs[2] = '{segs: 32'h0EC09290, gap: 4'd3, exp_d: 16'hF059, exp_p: 4'b1000, exp_bad: 1'b0};
    vecs[3] = '{segs: 32'h82FFF880, gap: 4'd0, exp_d: 16'h6078, exp_p: 4'h0, exp_bad: 1'b1};
    vecs[4] = '{segs: 32'h86C08E80, gap: 4'd2, exp_d: 16'hE0F8, exp_p: 4'h0, exp_bad: 1'b1};
    vecs[5] = '{segs: 32'h78787878, gap: 4'd0, exp_d: 16'h7777, exp_p: 4'hF, exp_bad: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_dp", 32'(dp), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_bad", 32'(bad_pattern), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // "1234" with commit latency measured from the start of the last digit
    fvb = fv_count;
    visit(0, 8'h99, 8);
    visit(1, 8'hB0, 8);
    visit(2, 8'hA4, 8);
    c0 = cyc;
    visit(3, 8'hF9, 8);
    hold(4'hF, 8'hFF, 6);
    check("scan1234_frames", 32'(fv_count - fvb), 32'd1);
    check("scan1234_latency", 32'(fv_cyc - c0), 32'd8);
    check("scan1234_digits", 32'(digits), 32'h1234);
    check("scan1234_dp", 32'(dp), 32'h0);

    // Glitch shorter than STABLE_CYCLES on digit 0 is rejected
    fvb = fv_count;
    visit(0, 8'hF9, 3);
    visit(0, 8'hC0, 8);
    visit(1, 8'hF9, 8);
    visit(2, 8'hA4, 8);
    visit(3, 8'hB0, 8);
    hold(4'hF, 8'hFF, 6);
    check("glitch_frames", 32'(fv_count - fvb), 32'd1);
    check("glitch_digits", 32'(digits), 32'h3210);
    check("glitch_bad", 32'(bad_pattern), 32'h0);

    // Vector table of full scans
    for (int v = 0; v < 6; v++) begin
      fvb = fv_count;
      for (int d = 0; d < 4; d++) begin
        visit(d, vecs[v].segs[d], 8);
        if (vecs[v].gap != 0) hold(4'hF, 8'hFF, int'(vecs[v].gap));
      end
      hold(4'hF, 8'hFF, 6);
      check($sformatf("vec%0d_frames", v), 32'(fv_count - fvb), 32'd1);
      check($sformatf("vec%0d_digits", v), 32'(digits), 32'(vecs[v].exp_d));
      check($sformatf("vec%0d_dp", v), 32'(dp), 32'(vecs[v].exp_p));
      check($sformatf("vec%0d_bad", v), 32'(bad_pattern), 32'(vecs[v].exp_bad));
    end

    // Stall: sel frozen on digit 0, stall rises 19 edges after the drive
    hold(4'hF, 8'hFF, 3);
    check("stall_idle", 32'(stall), 32'h0);
    sel_in = 4'hE;
    seg_in = 8'hC0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("stall_before", 32'(stall), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("stall_on", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    sel_in = 4'hF;
    seg_in = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_held", 32'(stall), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("stall_clear", 32'(stall), 32'h0);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame
    visit(2, 8'h83, 8);
    visit(3, 8'h88, 8);
    rst = 1'b0;
    hold(4'hF, 8'hFF, 3);
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_bad", 32'(bad_pattern), 32'h0);
    check("midrst_fv", 32'(frame_valid), 32'h0);
    rst = 1'b1;
    hold(4'hF, 8'hFF, 2);
    fvb = fv_count;
    visit(0, 8'hA1, 8);
    visit(1, 8'hC6, 8);
    hold(4'hF, 8'hFF, 6);
    check("midrst_partial_frames", 32'(fv_count - fvb), 32'd0);
    check("midrst_partial_digits", 32'(digits), 32'h0);
    visit(2, 8'h83, 8);
    visit(3, 8'h88, 8);
    hold(4'hF, 8'hFF, 6);
    check("midrst_frames", 32'(fv_count - fvb), 32'd1);
    check("midrst_abcd", 32'(digits), 32'hABCD);
    check("midrst_dp", 32'(dp), 32'h0);

    // Randomized scans against the frame model
    model_bad = 1'b0;
    last_idx  = -1;
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0;
      m_dp[i]  = 1'b0;
    end
    fvb    = fv_count;
    mon_en = 1'b1;
    for (int n = 0; n < 40; n++) rand_frame();
    hold(4'hF, 8'hFF, 12);
    mon_en = 1'b0;
    check("rand_pending", 32'(exp_q.size()), 32'd0);
    check("rand_frame_count", 32'(fv_count - fvb), 32'd40);
    check("rand_bad", 32'(bad_pattern), 32'(model_bad));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
